// File: rtl/cv32e40x_alu_b_bitenum.sv
// Iterative set-bit enumerator: streams the index of each set bit, LSB first.
// Optional delivered-count register enabled by CV32E40X_BITENUM_COUNT_EN.
module cv32e40x_alu_b_bitenum (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] operand_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        idx_valid_o,
    input  logic        idx_ready_i,
    output logic [4:0]  idx_o,
    output logic        last_o,
    output logic        done_o,
    output logic [5:0]  count_o
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mask_q, mask_d;
    logic        done_q, done_d;
    logic        cnt_clr, cnt_inc;
    logic        run;
    logic        hs;
    logic        one_hot;
    logic [4:0]  enc;
    logic [31:0] mask_dec;

    assign run      = (state_q == RUN);
    assign hs       = run & idx_ready_i;
    assign mask_dec = mask_q & (mask_q - 32'd1);
    assign one_hot  = (mask_q != 32'd0) && (mask_dec == 32'd0);

    always_comb begin
        enc = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (mask_q[i]) enc = 5'(i);
        end
    end

    // Index outputs are gated so an aborted mask never leaks out in IDLE.
    assign busy_o      = run;
    assign idx_valid_o = run;
    assign idx_o       = run ? enc : 5'd0;
    assign last_o      = run & one_hot;
    assign done_o      = done_q;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    mask_d  = operand_i;
                    cnt_clr = 1'b1;
                    if (operand_i != 32'd0) state_d = RUN;
                    else                    done_d  = 1'b1;
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                    mask_d  = 32'd0;
                end else if (hs) begin
                    mask_d  = mask_dec;
                    cnt_inc = 1'b1;
                    if (one_hot) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
        end
    end

`ifdef CV32E40X_BITENUM_COUNT_EN
    logic [5:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)          cnt_q <= 6'd0;
        else if (cnt_clr) cnt_q <= 6'd0;
        else if (cnt_inc) cnt_q <= cnt_q + 6'd1;
    end

    assign count_o = cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = cnt_clr ^ cnt_inc;
    assign count_o    = 6'h0;
`endif

endmodule

// File: tb/tb_cv32e40x_alu_b_bitenum.sv
// Directed bench for the set-bit enumerator.
module tb_cv32e40x_alu_b_bitenum;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [31:0] operand_i;
    logic        abort_i;
    logic        busy_o;
    logic        idx_valid_o;
    logic        idx_ready_i;
    logic [4:0]  idx_o;
    logic        last_o;
    logic        done_o;
    logic [5:0]  count_o;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef CV32E40X_BITENUM_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    cv32e40x_alu_b_bitenum dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .operand_i   (operand_i),
        .abort_i     (abort_i),
        .busy_o      (busy_o),
        .idx_valid_o (idx_valid_o),
        .idx_ready_i (idx_ready_i),
        .idx_o       (idx_o),
        .last_o      (last_o),
        .done_o      (done_o),
        .count_o     (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] ecnt(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] op);
        start_i   = 1'b1;
        operand_i = op;
        step();
        start_i   = 1'b0;
        operand_i = 32'd0;
    endtask

    task automatic beat(input string tag, input logic [4:0] idx,
                        input logic last);
        chk({tag, "_valid"}, 32'(idx_valid_o), 32'd1);
        chk({tag, "_idx"}, 32'(idx_o), 32'(idx));
        chk({tag, "_last"}, 32'(last_o), 32'(last));
    endtask

    task automatic idle_chk(input string tag, input logic done,
                            input logic [31:0] cnt);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_valid"}, 32'(idx_valid_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'(done));
        chk({tag, "_count"}, 32'(count_o), cnt);
    endtask

    logic [4:0] sparse_idx [4];

    initial begin
        sparse_idx = '{5'd0, 5'd2, 5'd16, 5'd31};
        rst         = 1'b1;
        start_i     = 1'b0;
        operand_i   = 32'd0;
        abort_i     = 1'b0;
        idx_ready_i = 1'b1;
        step();
        step();
        idle_chk("rst", 1'b0, 32'd0);
        chk("rst_idx", 32'(idx_o), 32'd0);
        chk("rst_last", 32'(last_o), 32'd0);
        rst = 1'b0;
        step();

        // sparse mask
        start(32'h8001_0005);
        chk("sp_busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            beat($sformatf("sp%0d", i), sparse_idx[i], i == 3);
            step();
        end
        idle_chk("sp_end", 1'b1, ecnt(4));
        step();
        chk("sp_done_pulse", 32'(done_o), 32'd0);

        // zero operand
        start(32'd0);
        idle_chk("zero", 1'b1, 32'd0);
        step();
        idle_chk("zero_after", 1'b0, 32'd0);

        // full operand
        start(32'hFFFF_FFFF);
        for (int i = 0; i < 32; i++) begin
            beat($sformatf("full%0d", i), 5'(i), i == 31);
            step();
        end
        idle_chk("full_end", 1'b1, ecnt(32));
        step();

        // backpressure
        idx_ready_i = 1'b0;
        start(32'h0000_0110);
        for (int i = 0; i < 3; i++) begin
            beat($sformatf("bp_stall%0d", i), 5'd4, 1'b0);
            step();
        end
        beat("bp_hold", 5'd4, 1'b0);
        idx_ready_i = 1'b1;
        step();
        beat("bp_second", 5'd8, 1'b1);
        idx_ready_i = 1'b0;
        step();
        beat("bp_second_hold", 5'd8, 1'b1);
        chk("bp_nodone", 32'(done_o), 32'd0);
        idx_ready_i = 1'b1;
        step();
        idle_chk("bp_end", 1'b1, ecnt(2));
        step();

        // abort wins over a concurrent handshake
        start(32'h0000_000F);
        beat("ab0", 5'd0, 1'b0);
        step();
        beat("ab1", 5'd1, 1'b0);
        step();
        beat("ab2", 5'd2, 1'b0);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        idle_chk("ab_idle", 1'b0, ecnt(2));
        chk("ab_idx", 32'(idx_o), 32'd0);
        step();
        idle_chk("ab_idle2", 1'b0, ecnt(2));
        start(32'h0000_0002);
        beat("ab_new", 5'd1, 1'b1);
        step();
        idle_chk("ab_new_end", 1'b1, ecnt(1));
        step();

        // start ignored while busy, then back-to-back start
        start(32'h0000_0003);
        beat("ig0", 5'd0, 1'b0);
        start_i   = 1'b1;
        operand_i = 32'h0000_00FF;
        step();
        start_i   = 1'b0;
        operand_i = 32'd0;
        beat("ig1", 5'd1, 1'b1);
        step();
        idle_chk("ig_end", 1'b1, ecnt(2));
        start(32'h0000_0040);
        beat("b2b", 5'd6, 1'b1);
        chk("b2b_busy", 32'(busy_o), 32'd1);
        step();
        idle_chk("b2b_end", 1'b1, ecnt(1));
        step();

        // reset mid-run
        start(32'h0000_00F0);
        beat("rr0", 5'd4, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_chk("rr", 1'b0, 32'd0);
        chk("rr_idx", 32'(idx_o), 32'd0);
        chk("rr_last", 32'(last_o), 32'd0);
        step();
        idle_chk("rr_after", 1'b0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
